alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter COUNT_W, default 8: width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: an operation request is present.
REQ-005 SHALL have port req_ready, output, 1: the sequencer accepts a request this cycle.
REQ-006 SHALL have port req_op, input, 3: ALU opcode (000 add, 001 sub, 010 or, 011 and, 100 not, 101 comp, 110 shr, 111 shl).
REQ-007 SHALL have port req_a, input, 8: operand A.
REQ-008 SHALL have port req_b, input, 8: operand B.
REQ-009 SHALL have port req_use_acc, input, 1: when 1, operand A is the accumulator instead of req_a.
REQ-010 SHALL have port alu_a, output, 8: drives ALU in_A.
REQ-011 SHALL have port alu_b, output, 8: drives ALU in_B.
REQ-012 SHALL have port alu_op, output, 3: drives ALU op.
REQ-013 SHALL have port alu_enable_out, output, 1: drives ALU in_enable_out.
REQ-014 SHALL have port alu_out, input, 8: ALU result bus.
REQ-015 SHALL have port alu_flags, input, 4: ALU flags, ordered {C,N,O,Z} at bits [3:0].
REQ-016 SHALL have port rsp_valid, output, 1: a result is held for the consumer.
REQ-017 SHALL have port rsp_ready, input, 1: the consumer takes the result.
REQ-018 SHALL have port rsp_data, output, 8: captured result.
REQ-019 SHALL have port rsp_flags, output, 4: captured flags, same bit order as alu_flags.
REQ-020 SHALL have port op_count, output, COUNT_W: count of completed responses.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, EXEC, CAPTURE and RESP, advancing one state per clock except where stated otherwise.
REQ-022 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1, and the FSM then goes IDLE->ISSUE.
REQ-023 SHALL register alu_a (the accumulator if req_use_acc=1, else req_a), alu_b and alu_op on acceptance, and hold them stable until the next acceptance.
REQ-024 SHALL drive alu_enable_out=0 in IDLE, ISSUE and RESP, and alu_enable_out=1 in EXEC and CAPTURE.
REQ-025 SHALL transition ISSUE->EXEC->CAPTURE unconditionally.
REQ-026 SHALL, on the CAPTURE->RESP edge, register alu_out into rsp_data and the accumulator, and alu_flags into rsp_flags, with no masking of the captured values.
REQ-027 SHALL assert rsp_valid in RESP only, so that rsp_valid is first high 3 cycles after the accept edge.
REQ-028 SHALL hold RESP, with rsp_data and rsp_flags stable, while rsp_ready=0 (backpressure of unlimited length).
REQ-029 SHALL, on an edge in RESP with rsp_ready=1, go RESP->IDLE and increment op_count modulo 2^COUNT_W (wrap from all-ones to 0).
REQ-030 SHALL NOT overlap operations; req_ready returns to 1 in the cycle after the response handshake, giving a minimum of 5 cycles per operation.
REQ-031 SHALL retain rsp_data, rsp_flags and the accumulator after the handshake, until the next capture.
REQ-032 SHALL ignore req_valid and all req_* inputs outside IDLE, and ignore rsp_ready outside RESP.

Reset
REQ-033 SHALL, while rst=1, force the state to IDLE and clear req_ready, rsp_valid and alu_enable_out to 0; req_ready rises to 1 after deassertion.
REQ-034 SHALL, while rst=1, clear alu_a, alu_b, alu_op, rsp_data, rsp_flags, the accumulator and op_count to 0.
REQ-035 SHALL, on reset asserted in any state including mid-operation, discard the in-flight operation without a response and without incrementing op_count.

Verification
REQ-036 Bench SHALL cover: add, A=0x03, B=0x11, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_data=0x14, rsp_flags=0000, op_count=1.
REQ-037 Bench SHALL cover: after the previous response, sub with use_acc=1, B=0x14 -> alu_a=0x14, rsp_data=0x00, Z=1; then add with use_acc=1, A ignored, B=0x05 -> rsp_data=0x05.
REQ-038 Bench SHALL cover: add, 0x40+0x41 with rsp_ready=0 for 6 cycles -> rsp_valid and rsp_data=0x81 held, flags N=1 O=1; req_ready=0 throughout; op_count increments exactly once after rsp_ready=1.
REQ-039 Bench SHALL cover: alu_enable_out observed -> 0,0,1,1,0 across IDLE, ISSUE, EXEC, CAPTURE, RESP for every op, with alu_a/alu_b/alu_op constant from ISSUE through RESP.
REQ-040 Bench SHALL cover: rst pulsed during EXEC -> alu_enable_out=0 immediately, no rsp_valid, op_count unchanged at 0, req_ready=1 after release.
REQ-041 Bench SHALL cover: COUNT_W=2 with 5 completed ops -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external 8-bit ALU and holds the
// captured result for a ready/valid consumer. The accumulator feeds operand A on request.
module alu_sequencer #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [7:0]         req_a,
  input  logic [7:0]         req_b,
  input  logic               req_use_acc,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_enable_out,
  input  logic [7:0]         alu_out,
  input  logic [3:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_data,
  output logic [3:0]         rsp_flags,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_enable;
  logic [7:0]         r_alu_a;
  logic [7:0]         r_alu_b;
  logic [2:0]         r_alu_op;
  logic [7:0]         r_acc;
  logic [7:0]         r_rsp_data;
  logic [3:0]         r_rsp_flags;
  logic [COUNT_W-1:0] r_op_count;
  logic               w_accept;
  logic               w_done;

  // r_req_ready is only ever high in IDLE, and stays low in the first cycle after reset.
  assign w_accept = r_req_ready & req_valid;
  assign w_done   = (r_state == S_RESP) & rsp_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_ISSUE;
      S_ISSUE:   w_state_next = S_EXEC;
      S_EXEC:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_RESP;
      S_RESP:    if (rsp_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_enable    <= 1'b0;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_op    <= 3'd0;
      r_acc       <= 8'h00;
      r_rsp_data  <= 8'h00;
      r_rsp_flags <= 4'h0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == S_IDLE);
      r_rsp_valid <= (w_state_next == S_RESP);
      r_enable    <= (w_state_next == S_EXEC) | (w_state_next == S_CAPTURE);
      if (w_accept) begin
        r_alu_a  <= req_use_acc ? r_acc : req_a;
        r_alu_b  <= req_b;
        r_alu_op <= req_op;
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_data  <= alu_out;
        r_acc       <= alu_out;
        r_rsp_flags <= alu_flags;
      end
      if (w_done) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign alu_enable_out = r_enable;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_op         = r_alu_op;
  assign rsp_data       = r_rsp_data;
  assign rsp_flags      = r_rsp_flags;
  assign op_count       = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU stub plus a transaction-level reference
// (accumulator value and completed-op count) checked stage by stage.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_use_acc;
  logic       rsp_ready;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;

  logic       req_ready,  req_ready2;
  logic [7:0] alu_a,      alu_a2;
  logic [7:0] alu_b,      alu_b2;
  logic [2:0] alu_op,     alu_op2;
  logic       alu_en,     alu_en2;
  logic       rsp_valid,  rsp_valid2;
  logic [7:0] rsp_data,   rsp_data2;
  logic [3:0] rsp_flags,  rsp_flags2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_acc;
  int         m_count;

  always #5 clk = ~clk;

  alu_sequencer #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable_out(alu_en),
    .alu_out(alu_out), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .op_count(op_count)
  );

  alu_sequencer #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_enable_out(alu_en2),
    .alu_out(alu_out), .alu_flags(alu_flags), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_flags(rsp_flags2),
    .op_count(op_count2)
  );

  // ALU semantics: returns {C,N,O,Z,result}.
  function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    logic       o;
    w = 9'd0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  o = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = ~a;
      3'd5: begin r = 8'd0 - a; o = (a == 8'h80); end
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: begin r = {a[6:0], 1'b0}; c = a[7]; end
    endcase
    return {c, r[7], o, (r == 8'h00), r};
  endfunction

  assign {alu_flags, alu_out} = alu_en ? alu_ref(alu_op, alu_a, alu_b) : 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    req_valid   = 1'($urandom);
    req_op      = 3'($urandom);
    req_a       = 8'($urandom);
    req_b       = 8'($urandom);
    req_use_acc = 1'($urandom);
  endtask

  // Called at a falling edge while idle; returns at the falling edge after the handshake.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input int stall);
    logic [7:0]  ea;
    logic [11:0] er;
    ea = ua ? m_acc : a;
    er = alu_ref(op, ea, b);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_en", {31'd0, alu_en}, 32'd0);
    chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_acc = ua;
    rsp_ready = 1'($urandom);
    @(negedge clk);
    chk("issue_en", {31'd0, alu_en}, 32'd0);
    chk("issue_ready", {31'd0, req_ready}, 32'd0);
    chk("issue_regs", {13'd0, alu_a, alu_b, alu_op}, {13'd0, ea, b, op});
    scramble();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("exec_cap_en", {31'd0, alu_en}, 32'd1);
      chk("exec_cap_valid", {30'd0, req_ready, rsp_valid}, 32'd0);
      chk("exec_cap_regs", {13'd0, alu_a, alu_b, alu_op}, {13'd0, ea, b, op});
      scramble();
      rsp_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("resp_en", {31'd0, alu_en}, 32'd0);
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_data", {20'd0, rsp_flags, rsp_data}, {20'd0, er});
    chk("resp_regs", {13'd0, alu_a, alu_b, alu_op}, {13'd0, ea, b, op});
    chk("resp_count", {24'd0, op_count}, 32'(m_count % 256));
    chk("twin_resp", {10'd0, rsp_valid2, alu_en2, rsp_flags2, rsp_data2, alu_a2},
        {10'd0, 1'b1, 1'b0, er, ea});
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      scramble();
      @(negedge clk);
      chk("stall_hold", {18'd0, req_ready, rsp_valid, rsp_flags, rsp_data},
          {18'd0, 1'b0, 1'b1, er});
      chk("stall_count", {24'd0, op_count}, 32'(m_count % 256));
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    m_count++;
    m_acc = er[7:0];
    chk("done_ready", {30'd0, req_ready, req_ready2}, 32'd3);
    chk("done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_count", {24'd0, op_count}, 32'(m_count % 256));
    chk("done_count2", {30'd0, op_count2}, 32'(m_count % 4));
    chk("done_retain", {20'd0, rsp_flags, rsp_data}, {20'd0, er});
    rsp_ready = 1'($urandom);
    $display("op=%0d a=%02h b=%02h use_acc=%0d stall=%0d -> data=%02h flags=%04b count=%0d count2=%0d",
             op, ea, b, ua, stall, rsp_data, rsp_flags, op_count, op_count2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'h00; req_b = 8'h00;
    req_use_acc = 1'b0; rsp_ready = 1'b0;
    m_acc = 8'h00; m_count = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {29'd0, req_ready, rsp_valid, alu_en}, 32'd0);
    chk("rst_regs", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    chk("rst_rsp", {12'd0, rsp_flags, rsp_data, op_count}, 32'd0);
    chk("rst_count2", {30'd0, op_count2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Reset while executing: operation is dropped with no response.
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h55; req_b = 8'h22; req_use_acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_en", {31'd0, alu_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {29'd0, req_ready, rsp_valid, alu_en}, 32'd0);
    chk("mid_rst_regs", {5'd0, alu_a, alu_b, alu_op, op_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_after", {29'd0, req_ready, rsp_valid, alu_en}, 32'd4);
    chk("mid_rst_count", {22'd0, op_count2, op_count}, 32'd0);

    run_op(3'd0, 8'h03, 8'h11, 1'b0, 0);
    chk("r036_data", {20'd0, rsp_flags, rsp_data}, 32'h014);
    chk("r036_count", {24'd0, op_count}, 32'd1);
    run_op(3'd1, 8'h99, 8'h14, 1'b1, 0);
    chk("r037_sub", {12'd0, alu_a, rsp_flags, rsp_data}, 32'h14100);
    run_op(3'd0, 8'hEE, 8'h05, 1'b1, 1);
    chk("r037_add", {24'd0, rsp_data}, 32'h05);
    run_op(3'd0, 8'h40, 8'h41, 1'b0, 6);
    chk("r038_data", {20'd0, rsp_flags, rsp_data}, 32'h681);
    chk("r038_count", {24'd0, op_count}, 32'd4);

    for (int op = 0; op < 8; op++) begin
      run_op(3'(op), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    end
    for (int n = 0; n < 20; n++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
